// File: rtl/ws2812_rx.sv
// WS2812 serial line receiver: decodes high-time-coded bits into 24-bit GRB pixels
// with a valid/ready output, frame (latch) detection and illegal-pulse reporting.
module ws2812_rx #(
  parameter int unsigned CLOCK_HZ     = 12_000_000,
  parameter int unsigned THRESHOLD_NS = 600,
  parameter int unsigned RESET_US     = 50,
  parameter int unsigned MAX_HIGH_NS  = 5000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        din,
  output logic [23:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        frame_end,
  output logic        error,
  output logic        overflow
);

  localparam int unsigned ThreshCycles =
      32'(64'(CLOCK_HZ) * 64'(THRESHOLD_NS) / 64'd1_000_000_000);
  localparam int unsigned ResetCycles  = 32'(64'(CLOCK_HZ) * 64'(RESET_US) / 64'd1_000_000);
  localparam int unsigned MaxHighCycles =
      32'(64'(CLOCK_HZ) * 64'(MAX_HIGH_NS) / 64'd1_000_000_000);

  localparam int unsigned LowW  = $clog2(ResetCycles + 1);
  localparam int unsigned HighW = $clog2(MaxHighCycles + 1);

  localparam logic [LowW-1:0]  LowReset   = LowW'(ResetCycles);
  localparam logic [LowW-1:0]  LowLast    = LowW'(ResetCycles - 1);
  localparam logic [HighW-1:0] HighThresh = HighW'(ThreshCycles);
  localparam logic [HighW-1:0] HighMax    = HighW'(MaxHighCycles);

  typedef enum logic [1:0] {StUnsync, StLow, StHigh} state_e;

  state_e            state_q, state_d;
  logic              sync_q, din_s_q;
  logic [LowW-1:0]   low_cnt_q, low_cnt_d;
  logic [HighW-1:0]  high_cnt_q, high_cnt_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [23:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_q, frame_d;
  logic              error_q, error_d;
  logic              ovf_q, ovf_d;
  logic              bit_val;
  logic              pix_done;
  logic [23:0]       pix;

  always_comb begin
    state_d    = state_q;
    low_cnt_d  = low_cnt_q;
    high_cnt_d = high_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frame_d    = 1'b0;
    error_d    = 1'b0;
    pix_done   = 1'b0;
    bit_val    = (high_cnt_q >= HighThresh);
    pix        = {shift_q[22:0], bit_val};

    case (state_q)
      StUnsync: begin
        if (din_s_q) begin
          low_cnt_d = '0;
        end else if (low_cnt_q == LowLast) begin
          // Saturate so the entry into StLow does not produce a frame_end.
          low_cnt_d = LowReset;
          state_d   = StLow;
        end else begin
          low_cnt_d = low_cnt_q + 1'b1;
        end
      end
      StLow: begin
        if (din_s_q) begin
          // This edge already sampled the first high cycle of the pulse.
          high_cnt_d = HighW'(1);
          state_d    = StHigh;
        end else if (low_cnt_q == LowLast) begin
          low_cnt_d = LowReset;
          frame_d   = 1'b1;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else if (low_cnt_q != LowReset) begin
          low_cnt_d = low_cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (din_s_q) begin
          if (high_cnt_q >= HighMax) begin
            error_d   = 1'b1;
            bit_cnt_d = '0;
            shift_d   = '0;
            low_cnt_d = '0;
            state_d   = StUnsync;
          end else begin
            high_cnt_d = high_cnt_q + 1'b1;
          end
        end else begin
          shift_d   = pix;
          low_cnt_d = LowW'(1);
          state_d   = StLow;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            pix_done  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = StUnsync;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (pix_done) begin
      if (!valid_q || data_ready) begin
        data_d  = pix;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StUnsync;
      sync_q     <= 1'b0;
      din_s_q    <= 1'b0;
      low_cnt_q  <= '0;
      high_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      frame_q    <= 1'b0;
      error_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= din;
      din_s_q    <= sync_q;
      low_cnt_q  <= low_cnt_d;
      high_cnt_q <= high_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      frame_q    <= frame_d;
      error_q    <= error_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_end  = frame_q;
  assign error      = error_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed + randomized bench for ws2812_rx; a pulse-level model turns each sent
// high time into a bit and collects expected pixels for comparison.
module tb_ws2812_rx;

  localparam longint ClkHz    = 12_000_000;
  localparam int     Thresh   = int'(ClkHz * 600 / 1_000_000_000);
  localparam int     ResetLen = int'(ClkHz * 50 / 1_000_000);

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        din = 1'b0;
  logic        data_ready = 1'b0;
  logic [23:0] data_out;
  logic        data_valid, frame_end, error, overflow;

  int checks = 0;
  int errors = 0;

  int vcyc = 0;
  int fe_cnt = 0;
  int err_cnt = 0;
  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];

  logic [23:0] model_px = '0;
  int          model_bits = 0;
  bit          model_on = 1'b1;

  ws2812_rx dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .din       (din),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_end (frame_end),
    .error     (error),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (data_valid) vcyc <= vcyc + 1;
    if (data_valid && data_ready) got_q.push_back(data_out);
    if (frame_end) fe_cnt <= fe_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    model_px   = '0;
    model_bits = 0;
  endtask

  task automatic model_bit(input int h);
    if (model_on) begin
      model_px = {model_px[22:0], (h >= Thresh)};
      model_bits++;
      if (model_bits == 24) begin
        exp_q.push_back(model_px);
        model_bits = 0;
      end
    end
  endtask

  task automatic send_bit(input int h, input int l);
    din = 1'b1;
    repeat (h) tick();
    din = 1'b0;
    repeat (l) tick();
    model_bit(h);
  endtask

  task automatic send_px(input logic [23:0] px);
    for (int i = 23; i >= 0; i--) begin
      if (px[i]) send_bit(10, 5);
      else send_bit(4, 11);
    end
  endtask

  task automatic send_rand_px();
    logic [23:0] v;
    v = 24'($urandom);
    for (int i = 23; i >= 0; i--) begin
      if (v[i]) send_bit(int'($urandom_range(60, 7)), int'($urandom_range(20, 2)));
      else send_bit(int'($urandom_range(6, 1)), int'($urandom_range(20, 2)));
    end
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) tick();
  endtask

  task automatic compare_pixels(input string tag);
    int n;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_pixel"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'h0);
    check({tag, "_valid"}, 32'(data_valid), 32'h0);
    check({tag, "_frame_end"}, 32'(frame_end), 32'h0);
    check({tag, "_error"}, 32'(error), 32'h0);
    check({tag, "_overflow"}, 32'(overflow), 32'h0);
  endtask

  initial begin
    int v0, f0, e0;
    logic [23:0] px;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;

    // Known pixel with full lead-in; last bit checks the decode latency
    data_ready = 1'b1;
    v0 = vcyc; f0 = fe_cnt; e0 = err_cnt;
    idle(700);
    px = 24'hA50FC3;
    for (int i = 23; i >= 1; i--) begin
      if (px[i]) send_bit(10, 5);
      else send_bit(4, 11);
    end
    din = 1'b1;
    repeat (10) tick();
    din = 1'b0;
    tick();
    tick();
    check("latency_early", 32'(data_valid), 32'h0);
    tick();
    check("latency_valid", 32'(data_valid), 32'h1);
    check("latency_data", 32'(data_out), 32'hA50FC3);
    model_bit(10);
    tick();
    check("accept_clears_valid", 32'(data_valid), 32'h0);
    idle(20);
    check("basic_valid_cycles", 32'(vcyc - v0), 32'd1);
    check("basic_no_error", 32'(err_cnt - e0), 32'd0);
    check("basic_no_frame_end", 32'(fe_cnt - f0), 32'd0);
    compare_pixels("basic");

    // Threshold boundary 6/7/8 and the longest legal pulse
    send_bit(6, 5);
    send_bit(7, 5);
    send_bit(8, 5);
    send_bit(60, 5);
    for (int i = 0; i < 20; i++) send_bit(int'($urandom_range(12, 2)), 6);
    check("max_high_no_error", 32'(err_cnt - e0), 32'd0);
    compare_pixels("threshold");

    // Randomized back-to-back pixels
    for (int p = 0; p < 6; p++) send_rand_px();
    idle(10);
    compare_pixels("random");

    // Overflow: consumer stalled across two pixels
    data_ready = 1'b0;
    send_px(24'h123456);
    send_px(24'hABCDEF);
    check("ovf_valid", 32'(data_valid), 32'h1);
    check("ovf_hold_data", 32'(data_out), 32'h123456);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_no_transfer", 32'(got_q.size()), 32'd0);
    data_ready = 1'b1;
    tick();
    tick();
    check("ovf_valid_after", 32'(data_valid), 32'h0);
    exp_q.delete();
    exp_q.push_back(24'h123456);
    compare_pixels("ovf_transfer");

    // Partial pixel discarded by a latch period
    f0 = fe_cnt; v0 = vcyc;
    for (int i = 0; i < 10; i++) send_bit(10, 5);
    idle(ResetLen);
    model_clear();
    check("frame_end_once", 32'(fe_cnt - f0), 32'd1);
    idle(100);
    check("frame_end_no_repeat", 32'(fe_cnt - f0), 32'd1);
    check("frame_no_valid", 32'(vcyc - v0), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'h1);
    send_rand_px();
    idle(10);
    compare_pixels("after_frame");

    // Illegal long pulse, then resync
    e0 = err_cnt; f0 = fe_cnt;
    send_bit(10, 5);
    send_bit(4, 11);
    send_bit(61, 5);
    model_clear();
    check("error_once", 32'(err_cnt - e0), 32'd1);
    model_on = 1'b0;
    send_px(24'h5A5A5A);
    model_on = 1'b1;
    idle(10);
    check("unsync_ignored", 32'(got_q.size()), 32'd0);
    idle(ResetLen);
    check("unsync_no_frame_end", 32'(fe_cnt - f0), 32'd0);
    send_rand_px();
    idle(10);
    check("error_single", 32'(err_cnt - e0), 32'd1);
    compare_pixels("after_error");

    // Reset pulse mid-pixel
    e0 = err_cnt; f0 = fe_cnt; v0 = vcyc;
    for (int i = 0; i < 12; i++) send_bit(10, 5);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick();
    reset_n = 1'b1;
    model_clear();
    model_on = 1'b0;
    for (int i = 0; i < 12; i++) send_bit(10, 5);
    model_on = 1'b1;
    idle(700);
    check("mid_reset_no_valid", 32'(vcyc - v0), 32'd0);
    check("mid_reset_no_error", 32'(err_cnt - e0), 32'd0);
    check("mid_reset_no_frame_end", 32'(fe_cnt - f0), 32'd0);
    check("mid_reset_ovf_clear", 32'(overflow), 32'h0);
    send_rand_px();
    idle(10);
    compare_pixels("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
